// File: rtl/event_resp_checker.sv
// Initiator/checker for the single-event A->B->C handshake of delayed-response cells.
// Ports: clk, rst_n (sync, active-low), start, a_i/b_i/c_i in; ev_o, busy, done,
// pass, err_code, lat_a, lat_c out; err_cnt out only when CHK_ERRCNT_EN is defined.
module event_resp_checker #(
  parameter int unsigned CW        = 8,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned C_MIN_GAP = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          a_i,
  input  logic          b_i,
  input  logic          c_i,
  output logic          ev_o,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [1:0]    err_code,
  output logic [CW-1:0] lat_a,
  output logic [CW-1:0] lat_c
`ifdef CHK_ERRCNT_EN
  ,
  output logic [7:0]    err_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    FIRE,
    WAIT_A,
    WAIT_B,
    WAIT_C,
    DONE
  } state_t;

  localparam logic [CW-1:0] T_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MIN_GAP = CW'(C_MIN_GAP);

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d, cnt_inc;
  logic [CW-1:0] gap, gap_d, gap_inc;
  logic [CW-1:0] lat_a_d, lat_c_d;
  logic          ev_d, pass_d;
  logic [1:0]    err_d;

  // Latencies report the incremented count: 1 = seen in first wait cycle.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);
  assign gap_inc = (gap == '1) ? gap : gap + CW'(1);

  // gap doubles as the WAIT_B phase timer, then as the B->C gap.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    gap_d   = gap;
    ev_d    = ev_o;
    pass_d  = pass;
    err_d   = err_code;
    lat_a_d = lat_a;
    lat_c_d = lat_c;
    case (state)
      IDLE: begin
        if (start) state_d = FIRE;
      end
      FIRE: begin
        ev_d    = ~ev_o;
        pass_d  = 1'b0;
        err_d   = 2'b00;
        cnt_d   = '0;
        gap_d   = '0;
        state_d = WAIT_A;
      end
      WAIT_A: begin
        cnt_d = cnt_inc;
        if (a_i) begin
          lat_a_d = cnt_inc;
          gap_d   = '0;
          state_d = WAIT_B;
        end else if (cnt == T_LAST) begin
          err_d   = 2'b01;
          state_d = DONE;
        end
      end
      WAIT_B: begin
        cnt_d = cnt_inc;
        gap_d = gap_inc;
        if (b_i) begin
          gap_d   = '0;
          state_d = WAIT_C;
        end else if (gap == T_LAST) begin
          err_d   = 2'b10;
          state_d = DONE;
        end
      end
      WAIT_C: begin
        cnt_d = cnt_inc;
        gap_d = gap_inc;
        if (c_i) begin
          lat_c_d = cnt_inc;
          if (gap_inc >= MIN_GAP) pass_d = 1'b1;
          else                    err_d  = 2'b11;
          state_d = DONE;
        end else if (gap == T_LAST) begin
          err_d   = 2'b10;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      gap      <= '0;
      ev_o     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_code <= 2'b00;
      lat_a    <= '0;
      lat_c    <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      gap      <= gap_d;
      ev_o     <= ev_d;
      busy     <= (state_d != IDLE);
      done     <= (state_d == DONE);
      pass     <= pass_d;
      err_code <= err_d;
      lat_a    <= lat_a_d;
      lat_c    <= lat_c_d;
    end
  end

`ifdef CHK_ERRCNT_EN
  // DONE is only entered from a wait state, so this fires once per check.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (state_d == DONE && err_d != 2'b00 && err_cnt != 8'hff) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
